// File: rtl/alu_pkg.sv
// Shared constants, FSM state encoding and opcode decode for the shift scheduler.
package alu_pkg;

   localparam logic [4:0] OP_SLL = 5'd8;
   localparam logic [4:0] OP_SRL = 5'd12;
   localparam logic [4:0] OP_SRA = 5'd13;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_e;

   function automatic logic is_shift_op(input logic [4:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_shift_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after ptr wins.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   function automatic logic [IW-1:0] wrap_idx(input int base, input int off);
      return IW'((base + off) % N);
   endfunction

   logic found;

   // NOTE: every output gets a default before the loop so no path leaves one unassigned, which would infer a latch.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int off = 0; off < N; off++) begin
         if (!found && req[wrap_idx(int'(ptr), off)]) begin
            found                          = 1'b1;
            grant[wrap_idx(int'(ptr), off)] = 1'b1;
            idx                            = wrap_idx(int'(ptr), off);
         end
      end
   end

endmodule

// File: rtl/alu_shift_sched.sv
// Shares one registered shifter among NREQ requesters: accept, issue, wait one cycle, respond.
module alu_shift_sched
   import alu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                soc_clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*32-1:0]  req_dat1,
   input  logic [NREQ*32-1:0]  req_dat2,
   input  logic [NREQ*5-1:0]   req_op,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [31:0]         rsp_result,
   output logic                rsp_err,
   output logic                sh_dat_ready,
   output logic [31:0]         sh_dat1,
   output logic [31:0]         sh_dat2,
   output logic [4:0]          sh_op,
   input  logic [31:0]         sh_result,
   output logic                busy
);

   state_e          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [31:0]     dat1_q, dat1_d;
   logic [31:0]     dat2_q, dat2_d;
   logic [4:0]      op_q, op_d;
   logic [31:0]     result_q, result_d;
   logic            err_q, err_d;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  gidx;
   logic [4:0]      gop;

   rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (gidx)
   );

   assign gop = req_op[5*int'(gidx) +: 5];

   // The grant is only a handshake while idle and out of reset.
   assign req_ready    = (state_q == S_IDLE && reset) ? grant : '0;
   assign busy         = (state_q != S_IDLE);
   assign rsp_valid    = (state_q == S_RESP);
   assign sh_dat_ready = (state_q == S_ISSUE);
   assign sh_dat1      = dat1_q;
   assign sh_dat2      = dat2_q;
   assign sh_op        = op_q;
   assign rsp_id       = id_q;
   assign rsp_result   = result_q;
   assign rsp_err      = err_q;

   // NOTE: next-state logic uses blocking '=' in always_comb; the registers below use non-blocking '<=' only.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      id_d     = id_q;
      dat1_d   = dat1_q;
      dat2_d   = dat2_q;
      op_d     = op_q;
      result_d = result_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (|req_valid) begin
               id_d   = gidx;
               ptr_d  = IDW'((int'(gidx) + 1) % NREQ);
               dat1_d = req_dat1[32*int'(gidx) +: 32];
               dat2_d = req_dat2[32*int'(gidx) +: 32];
               op_d   = gop;
               err_d  = !is_shift_op(gop);
               if (is_shift_op(gop)) begin
                  state_d = S_ISSUE;
               end else begin
                  result_d = '0;
                  state_d  = S_RESP;
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            result_d = sh_result;
            state_d  = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge soc_clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         id_q     <= '0;
         dat1_q   <= '0;
         dat2_q   <= '0;
         op_q     <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         dat1_q   <= dat1_d;
         dat2_q   <= dat2_d;
         op_q     <= op_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_alu_shift_sched.sv
// Directed bench for alu_shift_sched with a behavioural registered shifter on the sh_* ports.
module tb_alu_shift_sched;

   localparam int NREQ = 2;
   localparam int IDW  = 1;

   logic                soc_clk = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*32-1:0]  req_dat1;
   logic [NREQ*32-1:0]  req_dat2;
   logic [NREQ*5-1:0]   req_op;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [31:0]         rsp_result;
   logic                rsp_err;
   logic                sh_dat_ready;
   logic [31:0]         sh_dat1;
   logic [31:0]         sh_dat2;
   logic [4:0]          sh_op;
   logic [31:0]         sh_result;
   logic                busy;

   int n_tests = 0;
   int n_fail  = 0;
   int sh_strobes = 0;

   always #5 soc_clk = ~soc_clk;

   alu_shift_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .soc_clk      (soc_clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_dat1     (req_dat1),
      .req_dat2     (req_dat2),
      .req_op       (req_op),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_result   (rsp_result),
      .rsp_err      (rsp_err),
      .sh_dat_ready (sh_dat_ready),
      .sh_dat1      (sh_dat1),
      .sh_dat2      (sh_dat2),
      .sh_op        (sh_op),
      .sh_result    (sh_result),
      .busy         (busy)
   );

   // Registered shifter with active-high reset driven from ~reset.
   always @(posedge soc_clk) begin
      if (~reset) begin
         sh_result <= '0;
      end else if (sh_dat_ready) begin
         case (sh_op)
            5'd8:    sh_result <= sh_dat1 << sh_dat2[4:0];
            5'd12:   sh_result <= sh_dat1 >> sh_dat2[4:0];
            5'd13:   sh_result <= $unsigned($signed(sh_dat1) >>> sh_dat2[4:0]);
            default: sh_result <= '0;
         endcase
      end
   end

   always @(posedge soc_clk) begin
      if (sh_dat_ready) sh_strobes <= sh_strobes + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge soc_clk);
   endtask

   task automatic set_req(input int id, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [4:0] op);
      req_dat1[32*id +: 32] = d1;
      req_dat2[32*id +: 32] = d2;
      req_op[5*id +: 5]     = op;
   endtask

   // Single legal request from requester id; entered and left at a negedge in IDLE.
   task automatic run_legal(input string tag, input int id, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [4:0] op,
                            input logic [31:0] exp);
      logic [1:0] onehot;
      onehot = 2'b00;
      onehot[id] = 1'b1;
      rsp_ready = 1'b0;
      set_req(id, d1, d2, op);
      req_valid = onehot;
      #1;
      check({tag, " req_ready"}, 32'(req_ready), 32'(onehot));
      tick();
      req_valid = '0;
      check({tag, " issue strobe"}, 32'(sh_dat_ready), 32'd1);
      check({tag, " sh_dat1"}, sh_dat1, d1);
      check({tag, " sh_dat2"}, sh_dat2, d2);
      check({tag, " sh_op"}, 32'(sh_op), 32'(op));
      tick();
      check({tag, " wait no strobe"}, 32'(sh_dat_ready), 32'd0);
      check({tag, " wait no rsp"}, 32'(rsp_valid), 32'd0);
      tick();
      check({tag, " rsp_valid T+3"}, 32'(rsp_valid), 32'd1);
      check({tag, " result"}, rsp_result, exp);
      check({tag, " id"}, 32'(rsp_id), 32'(id));
      check({tag, " err"}, 32'(rsp_err), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, " back to idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int strobes_before;
      logic [31:0] hold_result;

      reset     = 1'b0;
      req_valid = '0;
      req_dat1  = '0;
      req_dat2  = '0;
      req_op    = '0;
      rsp_ready = 1'b0;
      tick();
      tick();
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset sh_dat1", sh_dat1, 32'd0);
      check("reset sh_op", 32'(sh_op), 32'd0);
      check("reset rsp_result", rsp_result, 32'd0);
      reset = 1'b1;
      tick();

      run_legal("sll", 0, 32'h0000_0001, 32'h0000_001F, 5'd8,  32'h8000_0000);
      run_legal("sra", 1, 32'h8000_0000, 32'h0000_0024, 5'd13, 32'hF800_0000);
      run_legal("srl", 1, 32'h8000_0000, 32'h0000_0024, 5'd12, 32'h0800_0000);

      // Fairness: pointer is 0 after the last grant to requester 1.
      set_req(0, 32'h0000_0001, 32'd4, 5'd8);
      set_req(1, 32'h0000_00F0, 32'd4, 5'd12);
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rr grant %0d", i), 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
         tick();
         tick();
         tick();
         check($sformatf("rr rsp_valid %0d", i), 32'(rsp_valid), 32'd1);
         check($sformatf("rr id %0d", i), 32'(rsp_id), 32'(i % 2));
         check($sformatf("rr result %0d", i), rsp_result,
               (i % 2 == 0) ? 32'h0000_0010 : 32'h0000_000F);
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b0;

      // Illegal opcode followed by 10 cycles of backpressure.
      strobes_before = sh_strobes;
      set_req(0, 32'h1234_5678, 32'd3, 5'd5);
      req_valid = 2'b01;
      #1;
      check("illegal req_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 2'b11;
      check("illegal rsp_valid T+1", 32'(rsp_valid), 32'd1);
      check("illegal err", 32'(rsp_err), 32'd1);
      check("illegal result", rsp_result, 32'd0);
      check("illegal id", 32'(rsp_id), 32'd0);
      hold_result = rsp_result;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("bp rsp_valid %0d", i), 32'(rsp_valid), 32'd1);
         check($sformatf("bp result %0d", i), rsp_result, hold_result);
         check($sformatf("bp err %0d", i), 32'(rsp_err), 32'd1);
         check($sformatf("bp req_ready %0d", i), 32'(req_ready), 32'd0);
         check($sformatf("bp busy %0d", i), 32'(busy), 32'd1);
      end
      check("illegal no strobe", 32'(sh_strobes), 32'(strobes_before));
      rsp_ready = 1'b1;
      req_valid = '0;
      tick();
      rsp_ready = 1'b0;
      check("bp release rsp_valid", 32'(rsp_valid), 32'd0);
      check("bp release busy", 32'(busy), 32'd0);

      // Reset during WAIT; pointer would be 1 afterwards without the reset.
      set_req(0, 32'h0000_00FF, 32'd8, 5'd8);
      req_valid = 2'b01;
      tick();
      tick();
      check("pre-reset busy", 32'(busy), 32'd1);
      reset = 1'b0;
      tick();
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst rsp_id", 32'(rsp_id), 32'd0);
      check("rst rsp_result", rsp_result, 32'd0);
      check("rst rsp_err", 32'(rsp_err), 32'd0);
      check("rst sh_dat_ready", 32'(sh_dat_ready), 32'd0);
      check("rst sh_dat1", sh_dat1, 32'd0);
      check("rst sh_dat2", sh_dat2, 32'd0);
      check("rst sh_op", 32'(sh_op), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst req_ready", 32'(req_ready), 32'd0);
      req_valid = '0;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("post-rst quiet %0d", i), 32'(rsp_valid), 32'd0);
      end
      req_valid = 2'b11;
      #1;
      check("post-rst ptr 0", 32'(req_ready), 32'd1);
      req_valid = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_shift_sched.md
# alu_shift_sched

Round-robin scheduler that shares the single registered ALU shifter between NREQ requesters (e.g. integer issue slot and address-generation path). It accepts one shift request at a time over a valid/ready handshake and drives the shifter's operand/opcode/strobe inputs. It then captures the shifter result one cycle later and returns it, tagged with the requester index, over a valid/ready response channel. Illegal opcodes are rejected without touching the shifter.

## Interface
Parameters:
- NREQ, 2, number of requesters (legal 2..8)
- IDW, $clog2(NREQ), width of requester index

Ports:
- soc_clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_dat1  in  NREQ*32  value to shift, requester i in bits [32i+31:32i]
- req_dat2  in  NREQ*32  shift amount source, only bits [4:0] meaningful
- req_op  in  NREQ*5  opcode: 8 SLL, 12 SRL, 13 SRA
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of requester that owns the result
- rsp_result  out  32  shift result
- rsp_err  out  1  opcode was not 8/12/13; rsp_result is 0
- sh_dat_ready  out  1  one-cycle strobe to shifter
- sh_dat1  out  32  shifter operand 1
- sh_dat2  out  32  shifter operand 2
- sh_op  out  5  shifter opcode
- sh_result  in  32  shifter registered output
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, rr_arbiter picks winner g; req_ready[g]=1 combinationally in that cycle (handshake complete). Latch dat1/dat2/op/g. Legal op -> ISSUE; illegal op -> RESP with rsp_err=1, result 0 (shifter untouched). No req_valid -> stay.
- ISSUE: sh_dat_ready=1 for exactly this cycle; sh_dat1/sh_dat2/sh_op show latched values -> WAIT.
- WAIT: sh_result valid; capture into result register at end of cycle -> RESP.
- RESP: rsp_valid=1, rsp_id/rsp_result/rsp_err stable; on rsp_ready -> IDLE. Stalls indefinitely otherwise, holding all outputs.
- req_ready is 0 in every state except IDLE; no new request accepted until response retired.
- Round robin: priority pointer = last granted index + 1 (mod NREQ); pointer updates only on an accepted request. After reset requester 0 has top priority.
- Shift amount forwarded unmodified (shifter uses dat2[4:0]); sh_dat1/sh_dat2/sh_op hold latched values outside ISSUE.
- Opcodes other than 8/12/13 (including 0 and 31) are illegal.

## Timing
- Reset (reset=0 at a clock edge): state IDLE, pointer 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_err 0, sh_dat_ready 0, sh_dat1/sh_dat2 0, sh_op 0, busy 0. Reset mid-operation aborts: in-flight request dropped, no response produced.
- Legal op: accept at cycle T, sh_dat_ready at T+1, rsp_valid first at T+3. Back-to-back with rsp_ready held 1: next accept at T+4 (4-cycle throughput).
- Illegal op: accept at T, rsp_valid at T+1.
- rsp_ready high while rsp_valid low is ignored.
- Requester deasserting req_valid while not granted: allowed, no effect.

## Structure
- alu_pkg: opcode constants OP_SLL=5'd8, OP_SRL=5'd12, OP_SRA=5'd13; state enum (IDLE, ISSUE, WAIT, RESP); function is_shift_op.
- Sub-module rr_arbiter (param N): req vector + pointer in, one-hot grant and index out, purely combinational; pointer register lives in alu_shift_sched.
- Bench instantiates the real shifter against sh_* ports, with its active-high reset driven from ~reset.

## Test plan
- Single SLL: req 0, dat1=0x0000_0001, dat2=0x1F, op 8 -> rsp_valid at T+3, result 0x8000_0000, id 0, err 0.
- SRA sign fill: req 1, dat1=0x8000_0000, dat2=0x24 (amount 4), op 13 -> result 0xF800_0000, id 1; same with op 12 -> 0x0800_0000.
- Fairness: NREQ=2, both req_valid held high, rsp_ready=1 -> grants alternate 0,1,0,1; accepts every 4 cycles.
- Illegal op 5 -> rsp_valid at T+1, err 1, result 0, sh_dat_ready never asserted.
- Backpressure: rsp_ready low 10 cycles -> rsp_* stable, req_ready all 0, busy 1; release -> IDLE next cycle.
- Reset during WAIT -> all outputs at reset values next cycle, no rsp_valid thereafter without a new request.
